pause_dim_ctrl: RTL and testbench
=================================

# pause_dim_ctrl

Parametrised pause arbiter and video dimmer between the OSD/HPS status logic and the video output path of the Aznable emu top level. Merges a user toggle button, OSD-open state and N independent pause request sources into a single CPU pause. After a programmable idle interval it fades the RGB stream down in vblank-aligned steps. Generalises the fixed 8/8/8, single-request pause unit with per-channel widths, multiple request sources, a stepped fade and a cycle-count timeout.

## Interface
- RW, default 8: red channel width
- GW, default 8: green channel width
- BW, default 8: blue channel width
- NUM_SRC, default 2: number of external pause request inputs (≥1)
- DIM_CYCLES, default 240_000_000: clk_sys cycles paused before fading starts (10 s at 24 MHz, ≥2)
- MAX_SHIFT, default 3: final fade level, as a right-shift count (1..min(RW,GW,BW))

Ports:
- clk_sys  in  1  system clock; all logic is in this single domain
- reset_n  in  1  asynchronous, active-low reset
- user_button  in  1  pause toggle, level; rising edge toggles
- osd_open  in  1  OSD currently displayed
- pause_request  in  NUM_SRC  per-source pause hold, level
- options  in  2  [0] pause while OSD open; [1] dim enable; 1 = enabled
- vblank  in  1  vertical blank from video timing
- rgb_in  in  RW+GW+BW  {R,G,B}, R in the MSBs
- rgb_out  out  RW+GW+BW  dimmed {R,G,B}
- pause_cpu  out  1  CPU/core pause
- dim_level  out  $clog2(MAX_SHIFT+1)  current fade shift
- dimmed  out  1  fade complete (level == MAX_SHIFT)

## Operation
- user_pause latch toggles on each rising edge of user_button, whether or not other pause sources are active.
- pause_req = user_pause | (osd_open & options[0]) | (|pause_request).
- Rising-edge detectors on user_button and vblank are registered. The first sampled level after reset counts as the previous value, i.e. 0.
- FSM states:
  - RUN: pause_req → PAUSED.
  - PAUSED: idle counter increments each cycle. When counter == DIM_CYCLES-1 and options[1] = 1 → FADING. If options[1] = 0, the counter saturates at DIM_CYCLES-1.
  - FADING: each vblank rising edge increments dim_level. Reaching MAX_SHIFT → DIMMED.
  - DIMMED: hold.
- From any non-RUN state:
  - !pause_req → RUN, with counter and level cleared.
  - options[1] falling → PAUSED, with level cleared and counter kept saturated. Fading resumes on the next options[1] = 1, starting with the next vblank edge.
- Each channel of rgb_out is that channel of rgb_in logically shifted right by dim_level. Widths are preserved and MSBs are zero-filled.
- Counter width is $clog2(DIM_CYCLES). It never wraps.

## Timing
- Reset values: rgb_out = 0, pause_cpu = 0, dim_level = 0, dimmed = 0, state RUN, user_pause = 0, counter = 0.
- pause_cpu is registered. It rises 1 cycle after pause_req rises, which is 2 cycles after the user_button edge because the edge detect adds a register. It falls 1 cycle after pause_req falls.
- rgb_out is registered with 1-cycle latency from rgb_in in every state. A dim_level change takes effect on the cycle after it updates.
- FADING is entered DIM_CYCLES cycles after entering PAUSED.
- A vblank edge in the same cycle as entering FADING is not counted.
- pause_req deasserting in the same cycle as a vblank edge: the release wins, and the level goes to 0.
- dimmed is registered and equals (dim_level == MAX_SHIFT).
- Asserting reset_n low mid-fade clears all outputs immediately, without waiting for a clock edge.

## Structure
- Package pause_dim_pkg holds:
  - state enum (RUN, PAUSED, FADING, DIMMED)
  - option bit index constants OPT_PAUSE_OSD = 0, OPT_DIM_EN = 1
- Sub-module pause_dim_timer: saturating idle counter with clear/enable inputs and a terminal-count output. Parameter DIM_CYCLES.
- Top level contains the edge detectors, pause merge, FSM and the RGB shift stage.

## Test plan
Parameters for all scenarios: DIM_CYCLES = 16, MAX_SHIFT = 3, 8/8/8, NUM_SRC = 2.
- Reset: drive reset_n = 0 with rgb_in = FFFFFF → rgb_out = 000000 and pause_cpu = 0. Release reset; 2 cycles later rgb_out = FFFFFF.
- Toggle: one user_button pulse → pause_cpu = 1 two cycles later. A second pulse clears it. With pause_request = 01 held, a user pulse leaves pause_cpu = 1.
- OSD gating: osd_open = 1 with options = 00 → pause_cpu stays 0. With options = 01 → pause_cpu = 1; dropping osd_open → 0.
- Fade: pause held, options = 11, rgb_in = FF8040.
  - No change before cycle 16.
  - Then one vblank pulse per edge gives rgb_out 7F4020, then 3F2010, then 1F1008.
  - dimmed = 1 after the third edge; a fourth edge causes no change.
- Release and disable:
  - Mid-fade at level 2, drop all pause sources → pause_cpu = 0, level 0, rgb_out = FF8040 within 2 cycles.
  - Repeat and instead clear options[1] → level 0, pause_cpu stays 1.
- Async reset: assert reset_n low in DIMMED → outputs zero before the next clk_sys edge. After release, state is RUN and the user_pause latch is clear.

Source files
------------

// File: rtl/pause_dim_pkg.sv
// Shared types and constants for the pause arbiter / video dimmer.
//   state_t       : arbiter FSM states
//   OPT_PAUSE_OSD : options bit that lets an open OSD pause the core
//   OPT_DIM_EN    : options bit that enables the idle fade
package pause_dim_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    FADING = 2'd2,
    DIMMED = 2'd3
  } state_t;

  localparam int OPT_PAUSE_OSD = 0;
  localparam int OPT_DIM_EN    = 1;

endpackage

// File: rtl/pause_dim_timer.sv
// Saturating idle counter that measures how long the core has been paused.
//   clk_sys, reset_n : clock and asynchronous active-low reset
//   clr              : synchronous clear (wins over en)
//   en               : count enable; counting stops at DIM_CYCLES-1
//   tc               : terminal count reached (count == DIM_CYCLES-1)
module pause_dim_timer
  import pause_dim_pkg::*;
#(
  parameter int DIM_CYCLES = 240_000_000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (DIM_CYCLES > 1) ? $clog2(DIM_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIM_CYCLES - 1);

  logic [CNT_W-1:0] cnt_p1;

  assign tc = (cnt_p1 == CNT_LAST);

  // Stage p1: counter holds at the terminal value instead of wrapping
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_p1 <= '0;
    end else if (clr) begin
      cnt_p1 <= '0;
    end else if (en && !tc) begin
      cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

endmodule

// File: rtl/pause_dim_ctrl.sv
// Pause arbiter and stepped video dimmer.
// Merges a toggle button, OSD-open state and NUM_SRC pause holds into one
// registered CPU pause; after DIM_CYCLES paused cycles it fades RGB down by
// one right-shift per vblank until MAX_SHIFT is reached.
//   clk_sys, reset_n : clock and asynchronous active-low reset
//   user_button      : pause toggle (rising edge toggles)
//   osd_open         : OSD displayed
//   pause_request    : per-source pause holds
//   options          : [0] pause while OSD open, [1] dim enable
//   vblank           : vertical blank
//   rgb_in / rgb_out : {R,G,B} pixel in / dimmed pixel out (1-cycle latency)
//   pause_cpu        : core pause
//   dim_level        : current fade shift
//   dimmed           : fade complete
module pause_dim_ctrl
  import pause_dim_pkg::*;
#(
  parameter int RW         = 8,
  parameter int GW         = 8,
  parameter int BW         = 8,
  parameter int NUM_SRC    = 2,
  parameter int DIM_CYCLES = 240_000_000,
  parameter int MAX_SHIFT  = 3
) (
  input  logic                             clk_sys,
  input  logic                             reset_n,
  input  logic                             user_button,
  input  logic                             osd_open,
  input  logic [NUM_SRC-1:0]               pause_request,
  input  logic [1:0]                       options,
  input  logic                             vblank,
  input  logic [RW+GW+BW-1:0]              rgb_in,
  output logic [RW+GW+BW-1:0]              rgb_out,
  output logic                             pause_cpu,
  output logic [$clog2(MAX_SHIFT+1)-1:0]   dim_level,
  output logic                             dimmed
);

  localparam int PW    = RW + GW + BW;
  localparam int LVL_W = $clog2(MAX_SHIFT + 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(MAX_SHIFT);

  logic             btn_p0;
  logic             btn_rise_p1;
  logic             vb_p0;
  logic             vb_rise_p1;
  logic             user_pause;
  logic             pause_req;
  logic             timer_clr;
  logic             idle_tc;
  state_t           state;
  state_t           state_nxt;
  logic [LVL_W-1:0] level_nxt;

  // Each channel shifted independently so bits never bleed between colours.
  function automatic logic [PW-1:0] dim_rgb(input logic [PW-1:0] px,
                                            input logic [LVL_W-1:0] sh);
    logic [RW-1:0] r;
    logic [GW-1:0] g;
    logic [BW-1:0] b;
    r = px[PW-1 -: RW] >> sh;
    g = px[GW+BW-1 -: GW] >> sh;
    b = px[BW-1:0] >> sh;
    return {r, g, b};
  endfunction

  // Stage p0/p1: edge detectors; the rise pulse itself is registered
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      btn_p0      <= 1'b0;
      btn_rise_p1 <= 1'b0;
      vb_p0       <= 1'b0;
      vb_rise_p1  <= 1'b0;
      user_pause  <= 1'b0;
    end else begin
      btn_p0      <= user_button;
      btn_rise_p1 <= user_button & ~btn_p0;
      vb_p0       <= vblank;
      vb_rise_p1  <= vblank & ~vb_p0;
      if (btn_rise_p1) begin
        user_pause <= ~user_pause;
      end
    end
  end

  assign pause_req = user_pause
                   | (osd_open & options[OPT_PAUSE_OSD])
                   | (|pause_request);

  // Counter only runs while paused; releasing the pause restarts the interval.
  assign timer_clr = (state == RUN) || !pause_req;

  pause_dim_timer #(
    .DIM_CYCLES (DIM_CYCLES)
  ) u_timer (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clr     (timer_clr),
    .en      (1'b1),
    .tc      (idle_tc)
  );

  always_comb begin
    state_nxt = state;
    level_nxt = dim_level;
    if (state == RUN) begin
      if (pause_req) begin
        state_nxt = PAUSED;
      end
    end else if (!pause_req) begin
      // Release beats a coincident vblank edge.
      state_nxt = RUN;
      level_nxt = '0;
    end else if (!options[OPT_DIM_EN]) begin
      state_nxt = PAUSED;
      level_nxt = '0;
    end else begin
      case (state)
        PAUSED: begin
          if (idle_tc) begin
            state_nxt = FADING;
          end
        end
        FADING: begin
          if (vb_rise_p1) begin
            level_nxt = dim_level + 1'b1;
            if (level_nxt == LVL_MAX) begin
              state_nxt = DIMMED;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p1: FSM state, fade level and registered outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      dim_level <= '0;
      dimmed    <= 1'b0;
      pause_cpu <= 1'b0;
      rgb_out   <= '0;
    end else begin
      state     <= state_nxt;
      dim_level <= level_nxt;
      dimmed    <= (level_nxt == LVL_MAX);
      pause_cpu <= pause_req;
      rgb_out   <= dim_rgb(rgb_in, dim_level);
    end
  end

endmodule

// File: tb/tb_pause_dim_ctrl.sv
module tb_pause_dim_ctrl;
  import pause_dim_pkg::*;

  localparam int RW = 8, GW = 8, BW = 8, NUM_SRC = 2;
  localparam int DIM_CYCLES = 16, MAX_SHIFT = 3;
  localparam int LVL_W = $clog2(MAX_SHIFT + 1);
  localparam int PW = RW + GW + BW;

  logic               clk_sys = 1'b0;
  logic               reset_n;
  logic               user_button;
  logic               osd_open;
  logic [NUM_SRC-1:0] pause_request;
  logic [1:0]         options;
  logic               vblank;
  logic [PW-1:0]      rgb_in;
  logic [PW-1:0]      rgb_out;
  logic               pause_cpu;
  logic [LVL_W-1:0]   dim_level;
  logic               dimmed;

  pause_dim_ctrl #(
    .RW(RW), .GW(GW), .BW(BW), .NUM_SRC(NUM_SRC),
    .DIM_CYCLES(DIM_CYCLES), .MAX_SHIFT(MAX_SHIFT)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .user_button   (user_button),
    .osd_open      (osd_open),
    .pause_request (pause_request),
    .options       (options),
    .vblank        (vblank),
    .rgb_in        (rgb_in),
    .rgb_out       (rgb_out),
    .pause_cpu     (pause_cpu),
    .dim_level     (dim_level),
    .dimmed        (dimmed)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pause age in cycles, fade level as an integer,
  // pixel dimming as integer division by 2**level.
  int          m_user_pause, m_btn_prev, m_btn_edge, m_vb_prev, m_vb_edge;
  int          m_paused, m_age, m_fading, m_level, m_dimmed, m_pause_cpu;
  logic [23:0] m_rgb;

  function automatic logic [23:0] ref_dim(input logic [23:0] px, input int lvl);
    int r, g, b, d;
    d = 1 << lvl;
    r = int'(px[23:16]) / d;
    g = int'(px[15:8]) / d;
    b = int'(px[7:0]) / d;
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic model_reset();
    m_user_pause = 0; m_btn_prev = 0; m_btn_edge = 0; m_vb_prev = 0; m_vb_edge = 0;
    m_paused = 0; m_age = 0; m_fading = 0; m_level = 0; m_dimmed = 0;
    m_pause_cpu = 0; m_rgb = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int req, dim_en, n_paused, n_age, n_fading, n_level;
    req    = (m_user_pause != 0 || (osd_open && options[0]) || pause_request != 0) ? 1 : 0;
    dim_en = options[1] ? 1 : 0;
    n_paused = m_paused; n_age = m_age; n_fading = m_fading; n_level = m_level;
    if (m_paused == 0) begin
      if (req != 0) begin
        n_paused = 1; n_age = 0;
      end
    end else if (req == 0) begin
      n_paused = 0; n_age = 0; n_fading = 0; n_level = 0;
    end else if (dim_en == 0) begin
      n_fading = 0; n_level = 0;
      n_age = (m_age < DIM_CYCLES - 1) ? m_age + 1 : m_age;
    end else if (m_fading == 0) begin
      if (m_age >= DIM_CYCLES - 1) n_fading = 1;
      n_age = (m_age < DIM_CYCLES - 1) ? m_age + 1 : m_age;
    end else if (m_vb_edge != 0 && m_level < MAX_SHIFT) begin
      n_level = m_level + 1;
    end
    m_rgb       = ref_dim(rgb_in, m_level);
    m_pause_cpu = req;
    m_paused = n_paused; m_age = n_age; m_fading = n_fading; m_level = n_level;
    m_dimmed = (n_level == MAX_SHIFT) ? 1 : 0;
    if (m_btn_edge != 0) m_user_pause = (m_user_pause != 0) ? 0 : 1;
    m_btn_edge = (user_button && m_btn_prev == 0) ? 1 : 0;
    m_btn_prev = user_button ? 1 : 0;
    m_vb_edge  = (vblank && m_vb_prev == 0) ? 1 : 0;
    m_vb_prev  = vblank ? 1 : 0;
  endtask

  task automatic tick();
    if (reset_n) model_step();
    @(posedge clk_sys);
    #1;
    if (reset_n) begin
      chk("model_rgb_out", 32'(rgb_out), 32'(m_rgb));
      chk("model_pause_cpu", 32'(pause_cpu), 32'(m_pause_cpu));
      chk("model_dim_level", 32'(dim_level), 32'(m_level));
      chk("model_dimmed", 32'(dimmed), 32'(m_dimmed));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_btn();
    user_button = 1'b1; tick();
    user_button = 1'b0; tick();
  endtask

  task automatic pulse_vb();
    vblank = 1'b1; tick();
    vblank = 1'b0; tick();
    tick();
  endtask

  task automatic reach_fading();
    pause_request = 2'b01;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("no_fade_early_lvl", 32'(dim_level), 32'd0);
      chk("no_fade_early_rgb", 32'(rgb_out), 32'hFF8040);
    end
    ticks(4);
  endtask

  initial begin
    user_button = 0; osd_open = 0; pause_request = '0; options = 2'b00;
    vblank = 0; rgb_in = 24'hFFFFFF;
    reset_n = 1'b1;
    model_reset();
    #1 reset_n = 1'b0;
    @(posedge clk_sys); #1;
    chk("reset_rgb_out", 32'(rgb_out), 32'h0);
    chk("reset_pause_cpu", 32'(pause_cpu), 32'h0);
    chk("reset_dim_level", 32'(dim_level), 32'h0);
    chk("reset_dimmed", 32'(dimmed), 32'h0);
    reset_n = 1'b1;
    ticks(2);
    chk("post_reset_rgb", 32'(rgb_out), 32'hFFFFFF);

    // Toggle
    pulse_btn();
    chk("toggle_latency", 32'(pause_cpu), 32'h0);
    tick();
    chk("toggle_on", 32'(pause_cpu), 32'h1);
    pulse_btn(); tick();
    chk("toggle_off", 32'(pause_cpu), 32'h0);
    pause_request = 2'b01; ticks(2);
    pulse_btn(); tick();
    chk("toggle_with_src", 32'(pause_cpu), 32'h1);
    pulse_btn(); pause_request = 2'b00; ticks(2);
    chk("toggle_src_drop", 32'(pause_cpu), 32'h0);

    // OSD gating
    osd_open = 1'b1; options = 2'b00; ticks(3);
    chk("osd_not_gated", 32'(pause_cpu), 32'h0);
    options = 2'b01; ticks(2);
    chk("osd_gated", 32'(pause_cpu), 32'h1);
    osd_open = 1'b0; ticks(2);
    chk("osd_closed", 32'(pause_cpu), 32'h0);

    // Fade
    options = 2'b11; rgb_in = 24'hFF8040;
    reach_fading();
    pulse_vb(); chk("fade1", 32'(rgb_out), 32'h7F4020);
    pulse_vb(); chk("fade2", 32'(rgb_out), 32'h3F2010);
    pulse_vb(); chk("fade3", 32'(rgb_out), 32'h1F1008);
    chk("fade3_dimmed", 32'(dimmed), 32'h1);
    pulse_vb(); chk("fade4_hold", 32'(rgb_out), 32'h1F1008);
    chk("fade4_level", 32'(dim_level), 32'h3);

    // Release mid-fade
    pause_request = 2'b00; ticks(3);
    reach_fading();
    pulse_vb(); pulse_vb();
    chk("rel_level2", 32'(dim_level), 32'h2);
    pause_request = 2'b00; ticks(2);
    chk("rel_pause", 32'(pause_cpu), 32'h0);
    chk("rel_level", 32'(dim_level), 32'h0);
    chk("rel_rgb", 32'(rgb_out), 32'hFF8040);

    // Dim disable mid-fade
    reach_fading();
    pulse_vb(); pulse_vb();
    options = 2'b01; ticks(2);
    chk("dis_level", 32'(dim_level), 32'h0);
    chk("dis_pause", 32'(pause_cpu), 32'h1);
    chk("dis_rgb", 32'(rgb_out), 32'hFF8040);
    options = 2'b11; ticks(2);
    pulse_vb(); pulse_vb(); pulse_vb();
    chk("pre_areset_dimmed", 32'(dimmed), 32'h1);

    // Async reset in DIMMED
    reset_n = 1'b0; #1;
    chk("areset_rgb", 32'(rgb_out), 32'h0);
    chk("areset_pause", 32'(pause_cpu), 32'h0);
    chk("areset_level", 32'(dim_level), 32'h0);
    chk("areset_dimmed", 32'(dimmed), 32'h0);
    model_reset();
    pause_request = 2'b00;
    #2 reset_n = 1'b1;
    tick();
    chk("areset_state", 32'(dut.state), 32'(RUN));
    chk("areset_user_pause", 32'(dut.user_pause), 32'h0);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) user_button = ~user_button;
      if ($urandom_range(0, 29) == 0) osd_open = 1'($urandom);
      if ($urandom_range(0, 49) == 0) pause_request = 2'($urandom);
      if ($urandom_range(0, 79) == 0) options = 2'($urandom);
      vblank = ($urandom_range(0, 5) == 0);
      rgb_in = 24'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
